// File: rtl/log_pkg.sv
// Shared constants for the capture logger and its dump reader.
package log_pkg;

    localparam int unsigned LOG_ADDR_WIDTH = 15;
    localparam int unsigned LOG_DATA_WIDTH = 16;
    localparam int unsigned BYTES_PER_WORD = (2 * LOG_DATA_WIDTH) / 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Bytes in one {bram_a, bram_b} word for a given sample width.
    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return (2 * data_width) / 8;
    endfunction

endpackage

// File: rtl/log_dump_reader_if.sv
// Logger read port plus outgoing byte stream of the dump reader.
interface log_dump_reader_if
    import log_pkg::*;
#(
    parameter int unsigned AW = LOG_ADDR_WIDTH,
    parameter int unsigned DW = LOG_DATA_WIDTH
);
    logic              o_read_log;
    logic [AW-1:0]     o_addr_log_to_mem;
    logic [2*DW-1:0]   i_data_log_from_mem;
    logic [7:0]        o_byte;
    logic              o_byte_valid;
    logic              i_byte_ready;

    modport master (
        output o_read_log, o_addr_log_to_mem, o_byte, o_byte_valid,
        input  i_data_log_from_mem, i_byte_ready
    );

    modport slave (
        input  o_read_log, o_addr_log_to_mem, o_byte, o_byte_valid,
        output i_data_log_from_mem, i_byte_ready
    );
endinterface

// File: rtl/log_word_serializer.sv
// Loads one log word and hands it out MSB-first over valid/ready.
module log_word_serializer
    import log_pkg::*;
#(
    parameter int unsigned DATA_W = LOG_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [2*DATA_W-1:0] i_word,
    output logic [7:0]        o_byte,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last_accepted_c
);
    localparam int unsigned WORD_W = 2 * DATA_W;
    localparam int unsigned BYTES  = bytes_per_word(DATA_W);
    localparam int unsigned CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;

    // Word shift register, remaining-byte counter and valid flag.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg   <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else if (i_clear) begin
            o_valid <= 1'b0;
        end else if (i_load) begin
            shreg   <= i_word;
            cnt     <= CNT_W'(BYTES - 1);
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            shreg <= shreg << 8;
            if (cnt == '0) begin
                o_valid <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign o_byte            = shreg[WORD_W-1 -: 8];
    assign o_last_accepted_c = o_valid && i_ready && (cnt == '0);

endmodule

// File: rtl/log_dump_reader.sv
// Sweeps the full logger memory once and streams every word as bytes.
module log_dump_reader
    import log_pkg::*;
#(
    parameter int unsigned BRAM_ADDR_WIDTH = LOG_ADDR_WIDTH,
    parameter int unsigned BRAM_DATA_WIDTH = LOG_DATA_WIDTH,
    parameter int unsigned BRAM_LATENCY    = 1
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_abort,
    input  logic i_mem_full,
    output logic o_busy,
    output logic o_done,
    output logic o_err,
    log_dump_reader_if.master bus
);
    localparam int unsigned AW     = BRAM_ADDR_WIDTH;
    localparam int unsigned WAIT_W = (BRAM_LATENCY > 0) ? $clog2(BRAM_LATENCY + 1) : 1;

    logic [2:0]        state,    state_nxt;
    logic [AW-1:0]     addr,     addr_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              read_log, read_log_nxt;
    logic              busy_nxt, done_nxt, err_nxt;
    logic              load_c, clear_c, last_accepted_c;

    // State, address, wait counter and registered status outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            addr     <= '0;
            wait_cnt <= '0;
            read_log <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            wait_cnt <= wait_nxt;
            read_log <= read_log_nxt;
            o_busy   <= busy_nxt;
            o_done   <= done_nxt;
            o_err    <= err_nxt;
        end
    end

    // Next-state logic; abort and loss of mem_full override every busy state.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        wait_nxt     = wait_cnt;
        read_log_nxt = read_log;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        load_c       = 1'b0;
        clear_c      = 1'b0;
        if (state != ST_IDLE && (i_abort || !i_mem_full)) begin
            state_nxt    = ST_IDLE;
            read_log_nxt = 1'b0;
            clear_c      = 1'b1;
            err_nxt      = !i_mem_full;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_mem_full) begin
                            state_nxt    = ST_REQ;
                            addr_nxt     = '0;
                            read_log_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    state_nxt = ST_FETCH;
                    wait_nxt  = WAIT_W'(BRAM_LATENCY);
                end
                ST_FETCH: begin
                    if (wait_cnt == '0) begin
                        load_c    = 1'b1;
                        state_nxt = ST_SEND;
                    end else begin
                        wait_nxt = wait_cnt - WAIT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (last_accepted_c) begin
                        if (addr == '1) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_FETCH;
                            addr_nxt  = addr + AW'(1);
                            wait_nxt  = WAIT_W'(BRAM_LATENCY);
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt    = ST_IDLE;
                    read_log_nxt = 1'b0;
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    read_log_nxt = 1'b0;
                end
            endcase
        end
        busy_nxt = (state_nxt != ST_IDLE);
    end

    log_word_serializer #(
        .DATA_W (BRAM_DATA_WIDTH)
    ) u_ser (
        .clk               (clk),
        .i_rst_n           (i_rst_n),
        .i_load            (load_c),
        .i_clear           (clear_c),
        .i_word            (bus.i_data_log_from_mem),
        .o_byte            (bus.o_byte),
        .o_valid           (bus.o_byte_valid),
        .i_ready           (bus.i_byte_ready),
        .o_last_accepted_c (last_accepted_c)
    );

    assign bus.o_read_log        = read_log;
    assign bus.o_addr_log_to_mem = addr;

endmodule

// File: tb/tb_log_dump_reader.sv
// Randomized self-checking bench for log_dump_reader with a small memory.
module tb_log_dump_reader;
    import log_pkg::*;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 16;
    localparam int unsigned LAT   = 1;
    localparam int unsigned BYTES = (2 * DW) / 8;
    localparam int unsigned WORDS = 1 << AW;
    localparam int          DUMP_CYCLES = WORDS * (BYTES + LAT + 1) + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic mem_full = 1'b0;
    logic busy, done, err;

    log_dump_reader_if #(.AW(AW), .DW(DW)) bus ();

    log_dump_reader #(
        .BRAM_ADDR_WIDTH (AW),
        .BRAM_DATA_WIDTH (DW),
        .BRAM_LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_mem_full (mem_full),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Logger memory: one-cycle read latency, word = A0B0_0000 + address.
    always @(posedge clk) begin
        bus.i_data_log_from_mem <= 32'hA0B0_0000 + 32'(bus.o_addr_log_to_mem);
    end

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] rx[$];

    // Collect transferred bytes and count status pulses.
    always @(posedge clk) begin
        if (bus.o_byte_valid && bus.i_byte_ready) rx.push_back(bus.o_byte);
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected byte idx of a full dump: word idx/BYTES, sent most significant byte first.
    function automatic logic [7:0] ref_byte(input int idx);
        int unsigned w;
        int unsigned k;
        w = 32'hA0B0_0000 + 32'(idx / BYTES);
        k = 32'(idx % BYTES);
        return 8'((w >> (8 * (BYTES - 1 - k))) & 32'hFF);
    endfunction

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 32'(rx.size()), 32'(WORDS * BYTES));
        for (int i = 0; i < rx.size() && i < int'(WORDS * BYTES); i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(rx[i]), 32'(ref_byte(i)));
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready high with a stall on word 4 byte 2.
    task automatic run_dump(input int mode, output int cycles);
        int  hold;
        bit  bp_done;
        bit  seen;
        hold = 0;
        bp_done = 0;
        seen = 0;
        rx.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        bus.i_byte_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        check("start_addr", 32'(bus.o_addr_log_to_mem), 32'd0);
        check("start_read_log", 32'(bus.o_read_log), 32'd1);
        while (!seen && cycles < 4000) begin
            if (done) begin
                seen = 1;
            end else begin
                if (mode == 2 && !bp_done && bus.o_byte_valid && rx.size() == 4 * BYTES + 2) begin
                    hold = 5;
                    bp_done = 1;
                end
                if (hold > 0) begin
                    check("bp_valid", 32'(bus.o_byte_valid), 32'd1);
                    check("bp_byte", 32'(bus.o_byte), 32'h00);
                    bus.i_byte_ready = 1'b0;
                    hold--;
                end else if (mode == 1) begin
                    bus.i_byte_ready = 1'($urandom_range(0, 1));
                end else begin
                    bus.i_byte_ready = 1'b1;
                end
                @(negedge clk);
                cycles++;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        bus.i_byte_ready = 1'b1;
        @(negedge clk);
        check("end_busy", 32'(busy), 32'd0);
        check("end_read_log", 32'(bus.o_read_log), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int cyc;
        bus.i_byte_ready = 1'b1;
        mem_full = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_read_log", 32'(bus.o_read_log), 32'd0);
        check("rst_addr", 32'(bus.o_addr_log_to_mem), 32'd0);
        check("rst_valid", 32'(bus.o_byte_valid), 32'd0);
        check("rst_byte", 32'(bus.o_byte), 32'd0);
        rst_n = 1'b1;

        run_dump(0, cyc);
        check("dump_cycles", 32'(cyc), 32'(DUMP_CYCLES));
        check_stream("full");

        run_dump(2, cyc);
        check_stream("bp");

        repeat (2) begin
            run_dump(1, cyc);
            check_stream("rnd");
        end

        // Start refused while the logger is not full.
        err_cnt = 0;
        mem_full = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("refuse_err", 32'(err), 32'd1);
        check("refuse_read_log", 32'(bus.o_read_log), 32'd0);
        check("refuse_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("refuse_err_clear", 32'(err), 32'd0);
        check("refuse_busy2", 32'(busy), 32'd0);
        mem_full = 1'b1;
        @(negedge clk);
        check("refuse_err_count", 32'(err_cnt), 32'd1);

        // Abort while word 3 byte 1 is on the bus.
        rx.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        bus.i_byte_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(bus.o_byte_valid && rx.size() == 3 * BYTES + 1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached", 32'(cyc < 200), 32'd1);
        abort = 1'b1;
        bus.i_byte_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        bus.i_byte_ready = 1'b1;
        check("abort_valid", 32'(bus.o_byte_valid), 32'd0);
        check("abort_read_log", 32'(bus.o_read_log), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_done_count", 32'(done_cnt), 32'd0);
        check("abort_rx_len", 32'(rx.size()), 32'(3 * BYTES + 1));
        run_dump(0, cyc);
        check("restart_cycles", 32'(cyc), 32'(DUMP_CYCLES));
        check_stream("restart");

        // Logger drops full flag during FETCH.
        rx.delete();
        err_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        mem_full = 1'b0;
        @(negedge clk);
        check("mf_err", 32'(err), 32'd1);
        check("mf_busy", 32'(busy), 32'd0);
        check("mf_read_log", 32'(bus.o_read_log), 32'd0);
        check("mf_valid", 32'(bus.o_byte_valid), 32'd0);
        mem_full = 1'b1;
        repeat (8) @(negedge clk);
        check("mf_err_count", 32'(err_cnt), 32'd1);
        check("mf_rx_len", 32'(rx.size()), 32'd0);
        check("mf_done_count", 32'(done_cnt), 32'd0);

        // Asynchronous reset in the middle of a randomly stalled dump.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) begin
            bus.i_byte_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.i_byte_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_read_log", 32'(bus.o_read_log), 32'd0);
        check("mid_rst_addr", 32'(bus.o_addr_log_to_mem), 32'd0);
        check("mid_rst_valid", 32'(bus.o_byte_valid), 32'd0);
        check("mid_rst_byte", 32'(bus.o_byte), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_dump(0, cyc);
        check("post_rst_cycles", 32'(cyc), 32'(DUMP_CYCLES));
        check_stream("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
